// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
// Signed and unsigned per operation; quotient, remainder and divide-by-zero flag.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_e;

    state_e           state_q, state_d;
    logic             sgn_q, sgn_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             in_neg;
    logic             dvs_in_neg;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        sgn_d       = sgn_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        trial      = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff       = trial - {1'b0, dvs_q};
        in_neg     = is_signed & dividend[WIDTH-1];
        dvs_in_neg = is_signed & divisor[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    sgn_d     = is_signed;
                    dvd_neg_d = in_neg;
                    dvs_neg_d = dvs_in_neg;
                    dvs_d     = dvs_in_neg ? -divisor : divisor;
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    // Divide-by-zero keeps the raw dividend so it can be returned unchanged.
                    if (divisor == '0) begin
                        dvd_d   = dividend;
                        state_d = ZERO;
                    end else begin
                        dvd_d   = in_neg ? -dividend : dividend;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // MIN / -1 wraps back to MIN through plain WIDTH-bit negation.
                quotient_d  = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
                remainder_d = (sgn_q && dvd_neg_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            ZERO: begin
                quotient_d  = '1;
                remainder_d = dvd_q;
                dbz_d       = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sgn_q       <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sgn_q       <= sgn_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle integer divider for the processor datapath.
- Runs restoring division at one quotient bit per clock.
- Supports signed and unsigned operation, selected per operation.
- Returns quotient and remainder with a start/busy/done handshake.
- Flags divide-by-zero and completes it early.
- Successor to the fixed 32-bit quotient-only divider; used by the ALU/MDU for DIV/DIVU.

Parameters:
- WIDTH, 32: operand and result width in bits (must be ≥ 2).
- CNT_W, $clog2(WIDTH+1): width of the internal iteration counter (derived; do not override).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when idle
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  result quotient; holds until the next completion
- remainder  output  WIDTH  result remainder; holds until the next completion
- div_by_zero  output  1  set with done when divisor was 0; holds like the results

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers are cleared; any operation in flight is abandoned.
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and output load.
  - ZERO: divide-by-zero completion.
- IDLE, start=1 at edge N:
  - Latch is_signed, the operand signs, and the magnitudes: |x| when is_signed and the MSB is set, otherwise the raw value.
  - Magnitudes are WIDTH-bit unsigned, so |MIN| = 2^(WIDTH-1) is represented exactly.
  - Clear the partial remainder (WIDTH+1 bits) and the counter; busy=1.
  - Go to ZERO if divisor==0, else CALC.
- CALC, each edge:
  - r' = {r[WIDTH-1:0], dividend_mag[MSB]}; shift the dividend magnitude left by 1.
  - If r' ≥ divisor_mag: r = r' − divisor_mag and shift 1 into the quotient; else r = r' and shift 0.
  - Counter increments; after exactly WIDTH iterations (edges N+1..N+WIDTH) go to FIX.
- FIX, edge N+WIDTH+1:
  - quotient = negated magnitude quotient if signed and the operand signs differ.
  - remainder = negated magnitude remainder if signed and the dividend was negative.
  - Division truncates toward zero; the remainder takes the dividend's sign.
  - done=1 for one cycle, busy=0, state=IDLE.
- Latency: done is visible in the cycle after edge N+WIDTH+1, i.e. WIDTH+1 edges after start is accepted.
- ZERO, edge N+1:
  - quotient = all ones, remainder = dividend (raw, as captured), div_by_zero=1.
  - done=1, busy=0, state=IDLE.
- div_by_zero is cleared on the next non-zero completion.
- Signed overflow (MIN / −1):
  - Yields quotient=MIN, remainder=0, no flag.
  - This falls out of WIDTH-bit magnitude arithmetic and must not be special-cased to anything else.
- start while busy: ignored; inputs are not re-sampled and the in-flight operation is unaffected.
- start in the done cycle (state is IDLE): accepted; a back-to-back operation begins with no dead cycle.
- Input changes after capture have no effect on the result.
- done never asserts without a preceding accepted start; done and busy are never high together.

Test Plan:
- Unsigned, WIDTH=32: is_signed=0, dividend=100, divisor=7, start at edge 0 → busy 1..32, done at edge 33, quotient=14, remainder=2, div_by_zero=0.
- Signed: −7/2 → q=−3, r=−1; 7/−2 → q=−3, r=1; −7/−2 → q=3, r=−1; unsigned 0xFFFFFFF9/2 → q=0x7FFFFFFC, r=1.
- Divide by zero: dividend=0x1234, divisor=0 → done at edge 1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1. A following 9/3 clears the flag (q=3, r=0).
- Overflow and edge values:
  - Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
  - 5/9 → q=0, r=5.
- Handshake:
  - start pulsed at cycle 10 of a busy operation with different operands → ignored; the original result is returned on schedule.
  - start held high through done → a second operation launches in the done cycle and completes 33 edges later.
- Reset mid-CALC (edge 15):
  - All outputs 0 immediately (asynchronous), no done pulse.
  - A new start after reset deasserts completes correctly.
- Repeat the first scenario and the divide-by-zero scenario at WIDTH=8 (e.g. 200/13 → q=15, r=5; done after 9 edges).
